// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per producer (alu1, alu2, ld), round-robin
// grant of one slot per cycle onto a registered broadcast bus.
module cdb_arbiter #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              alu1_valid,
  input  logic              alu2_valid,
  input  logic              ld_valid,
  input  logic [TAG_W-1:0]  alu1_tag,
  input  logic [TAG_W-1:0]  alu2_tag,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic [DATA_W-1:0] alu1_value,
  input  logic [DATA_W-1:0] alu2_value,
  input  logic [DATA_W-1:0] ld_value,
  output logic              alu1_ready,
  output logic              alu2_ready,
  output logic              ld_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic [1:0]        cdb_src
);

  typedef enum logic [1:0] {
    SRC_ALU1 = 2'd0,
    SRC_ALU2 = 2'd1,
    SRC_LD   = 2'd2
  } src_e;

  logic [2:0]        full_q, full_d;
  logic [TAG_W-1:0]  tag_q [3];
  logic [TAG_W-1:0]  tag_d [3];
  logic [DATA_W-1:0] val_q [3];
  logic [DATA_W-1:0] val_d [3];
  src_e              ptr_q, ptr_d;
  src_e              src_q, src_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;

  logic [2:0]        req_valid;
  logic [TAG_W-1:0]  req_tag [3];
  logic [DATA_W-1:0] req_val [3];
  logic [2:0]        idx;
  logic [1:0]        win;
  logic              found;

  assign req_valid  = {ld_valid, alu2_valid, alu1_valid};
  assign req_tag[0] = alu1_tag;
  assign req_tag[1] = alu2_tag;
  assign req_tag[2] = ld_tag;
  assign req_val[0] = alu1_value;
  assign req_val[1] = alu2_value;
  assign req_val[2] = ld_value;

  assign alu1_ready = ~full_q[0];
  assign alu2_ready = ~full_q[1];
  assign ld_ready   = ~full_q[2];
  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_src    = src_q;

  // Scan offsets 2,1,0 so the slot nearest ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      idx = {1'b0, ptr_q} + 3'(2 - k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (full_q[idx[1:0]]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  always_comb begin
    full_d      = full_q;
    tag_d       = tag_q;
    val_d       = val_q;
    ptr_d       = ptr_q;
    src_d       = src_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    if (rdy) begin
      if (flush) begin
        full_d      = '0;
        cdb_valid_d = 1'b0;
        ptr_d       = SRC_ALU1;
      end else begin
        cdb_valid_d = found;
        if (found) begin
          cdb_tag_d   = tag_q[win];
          cdb_value_d = val_q[win];
          src_d       = src_e'(win);
          full_d[win] = 1'b0;
          unique case (win)
            2'd0:    ptr_d = SRC_ALU2;
            2'd1:    ptr_d = SRC_LD;
            default: ptr_d = SRC_ALU1;
          endcase
        end
        // Acceptance looks at full_q, so a slot granted this edge cannot refill until the next.
        for (int unsigned i = 0; i < 3; i++) begin
          if (req_valid[i] && !full_q[i]) begin
            full_d[i] = 1'b1;
            tag_d[i]  = req_tag[i];
            val_d[i]  = req_val[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= '0;
      ptr_q       <= SRC_ALU1;
      src_q       <= SRC_ALU1;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      full_q      <= full_d;
      ptr_q       <= ptr_d;
      src_q       <= src_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      for (int unsigned i = 0; i < 3; i++) begin
        tag_q[i] <= tag_d[i];
        val_q[i] <= val_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus queues expected broadcasts with their
// cycle numbers; a negedge monitor pops and compares each one the bus presents.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        alu1_valid, alu2_valid, ld_valid;
  logic [3:0]  alu1_tag, alu2_tag, ld_tag;
  logic [31:0] alu1_value, alu2_value, ld_value;
  logic        alu1_ready, alu2_ready, ld_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;

  typedef struct {
    int          cyc;
    logic [3:0]  tag;
    logic [31:0] val;
    logic [1:0]  src;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic rdy_edge = 1'b1;
  int   n;

  cdb_arbiter #(.TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu1_valid(alu1_valid), .alu2_valid(alu2_valid), .ld_valid(ld_valid),
    .alu1_tag(alu1_tag), .alu2_tag(alu2_tag), .ld_tag(ld_tag),
    .alu1_value(alu1_value), .alu2_value(alu2_value), .ld_value(ld_value),
    .alu1_ready(alu1_ready), .alu2_ready(alu2_ready), .ld_ready(ld_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_edge <= rdy;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] t, input logic [31:0] v, input logic [1:0] s);
    exp_t e;
    e.cyc = c; e.tag = t; e.val = v; e.src = s;
    q.push_back(e);
  endtask

  // Broadcasts held through a frozen edge are the same broadcast, so only edges with rdy=1 count.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && rdy_edge) begin
        if (cdb_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_cdb_valid", cdb_valid, 1'b0);
          end else begin
            e = q.pop_front();
            chk("cdb_cycle", 64'(cyc), 64'(e.cyc));
            chk("cdb_tag", cdb_tag, e.tag);
            chk("cdb_value", cdb_value, e.val);
            chk("cdb_src", cdb_src, e.src);
          end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk("cdb_valid_missing", cdb_valid, 1'b1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    alu1_valid = 1'b0; alu2_valid = 1'b0; ld_valid = 1'b0;
    alu1_tag = '0; alu2_tag = '0; ld_tag = '0;
    alu1_value = '0; alu2_value = '0; ld_value = '0;
    repeat (2) @(negedge clk);
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_cdb_tag", cdb_tag, 4'h0);
    chk("rst_cdb_value", cdb_value, 32'h0);
    chk("rst_cdb_src", cdb_src, 2'd0);
    chk("rst_ready", {alu1_ready, alu2_ready, ld_ready}, 3'b111);
    rst = 1'b1;
    @(negedge clk);

    // Single uncontested alu1 result: broadcast exactly two cycles later.
    n = cyc;
    alu1_valid = 1'b1; alu1_tag = 4'd5; alu1_value = 32'h1234;
    push(n + 2, 4'd5, 32'h1234, 2'd0);
    @(negedge clk);
    alu1_valid = 1'b0;
    chk("t1_alu1_ready_full", alu1_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_alu1_ready_free", alu1_ready, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    // All three at once with ptr=0: grants 0,1,2 on consecutive cycles.
    n = cyc;
    alu1_valid = 1'b1; alu1_tag = 4'd1; alu1_value = 32'hA1;
    alu2_valid = 1'b1; alu2_tag = 4'd2; alu2_value = 32'hA2;
    ld_valid   = 1'b1; ld_tag   = 4'd3; ld_value   = 32'hA3;
    push(n + 2, 4'd1, 32'hA1, 2'd0);
    push(n + 3, 4'd2, 32'hA2, 2'd1);
    push(n + 4, 4'd3, 32'hA3, 2'd2);
    @(negedge clk);
    alu1_valid = 1'b0; alu2_valid = 1'b0; ld_valid = 1'b0;
    chk("t2_all_full", {alu1_ready, alu2_ready, ld_ready}, 3'b000);
    repeat (4) @(negedge clk);

    // ld waiting while alu1 requests every cycle (ptr back at 0): alu1, ld, alu1.
    n = cyc;
    ld_valid = 1'b1; ld_tag = 4'd7; ld_value = 32'h70;
    push(n + 2, 4'd8, 32'h100, 2'd0);
    push(n + 3, 4'd7, 32'h70, 2'd2);
    push(n + 4, 4'd10, 32'h102, 2'd0);
    for (int j = 0; j < 4; j++) begin
      alu1_valid = 1'b1; alu1_tag = 4'(8 + j); alu1_value = 32'(32'h100 + j);
      if (j == 1) begin
        ld_valid = 1'b0;
        chk("t3_busy", {alu1_ready, ld_ready}, 2'b00);
      end
      @(negedge clk);
    end
    alu1_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    // alu1 granted, then 4 frozen cycles with alu2 still held; flush/valid ignored meanwhile.
    n = cyc;
    alu1_valid = 1'b1; alu1_tag = 4'hB; alu1_value = 32'hB0B0;
    alu2_valid = 1'b1; alu2_tag = 4'hC; alu2_value = 32'hC0FFEE;
    push(n + 2, 4'hB, 32'hB0B0, 2'd0);
    push(n + 7, 4'hC, 32'hC0FFEE, 2'd1);
    @(negedge clk);
    alu1_valid = 1'b0; alu2_valid = 1'b0;
    @(negedge clk);
    rdy = 1'b0; flush = 1'b1;
    ld_valid = 1'b1; ld_tag = 4'hD; ld_value = 32'hDD;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_frozen_valid", cdb_valid, 1'b1);
      chk("t4_frozen_tag", cdb_tag, 4'hB);
      chk("t4_frozen_ready", {alu2_ready, ld_ready}, 2'b01);
    end
    rdy = 1'b1; flush = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("t4_alu2_released", alu2_ready, 1'b1);
    repeat (2) @(negedge clk);

    // Flush with two slots full plus new requests: everything dropped, ptr back to 0.
    n = cyc;
    alu1_valid = 1'b1; alu1_tag = 4'd1; alu1_value = 32'h11;
    ld_valid   = 1'b1; ld_tag   = 4'd2; ld_value   = 32'h22;
    @(negedge clk);
    ld_valid = 1'b0;
    alu1_tag = 4'd3; alu1_value = 32'h33;
    alu2_valid = 1'b1; alu2_tag = 4'd4; alu2_value = 32'h44;
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_ready", {alu1_ready, alu2_ready, ld_ready}, 3'b111);
    chk("t5_flush_cdb_valid", cdb_valid, 1'b0);
    flush = 1'b0; alu1_valid = 1'b0;
    alu2_tag = 4'd6; alu2_value = 32'h66;
    ld_valid = 1'b1; ld_tag = 4'd7; ld_value = 32'h77;
    push(n + 4, 4'd6, 32'h66, 2'd1);
    push(n + 5, 4'd7, 32'h77, 2'd2);
    @(negedge clk);
    alu2_valid = 1'b0; ld_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset while a broadcast is on the bus and ld is still held.
    n = cyc;
    alu1_valid = 1'b1; alu1_tag = 4'd9; alu1_value = 32'h99;
    ld_valid   = 1'b1; ld_tag   = 4'hE; ld_value   = 32'hEE;
    push(n + 2, 4'd9, 32'h99, 2'd0);
    @(negedge clk);
    alu1_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("t6_pre_rst_valid", cdb_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("t6_async_valid", cdb_valid, 1'b0);
    chk("t6_async_tag", cdb_tag, 4'h0);
    chk("t6_async_value", cdb_value, 32'h0);
    chk("t6_async_ready", {alu1_ready, alu2_ready, ld_ready}, 3'b111);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, ROB rename-tag width.
REQ-002 SHALL have parameter DATA_W, default 32, result width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy  input  1  global enable; 0 freezes all state.
REQ-006 SHALL have port flush  input  1  misprediction clear, synchronous.
REQ-007 SHALL have ports alu1_valid/alu2_valid/ld_valid  input  1 each  requester result valid.
REQ-008 SHALL have ports alu1_tag/alu2_tag/ld_tag  input  TAG_W each  destination ROB entry.
REQ-009 SHALL have ports alu1_value/alu2_value/ld_value  input  DATA_W each  result data.
REQ-010 SHALL have ports alu1_ready/alu2_ready/ld_ready  output  1 each  holding slot free.
REQ-011 SHALL have port cdb_valid  output  1  broadcast valid, registered.
REQ-012 SHALL have port cdb_tag  output  TAG_W  broadcast ROB tag, registered.
REQ-013 SHALL have port cdb_value  output  DATA_W  broadcast data, registered.
REQ-014 SHALL have port cdb_src  output  2  granted source: 0=alu1, 1=alu2, 2=ld.

Function
REQ-015 SHALL keep one holding slot per source (full bit, tag, value); source index i: 0=alu1, 1=alu2, 2=ld.
REQ-016 SHALL drive <src>_ready = !full[i], combinational from register only, no dependence on any valid input.
REQ-017 SHALL capture tag/value into slot i and set full[i] at an edge where rdy=1, flush=0, <src>_valid=1 and full[i]=0.
REQ-018 SHALL ignore <src>_valid while full[i]=1; the requester holds its data until ready.
REQ-019 SHALL hold a 2-bit round-robin pointer ptr in {0,1,2}; search order ptr, ptr+1, ptr+2 (mod 3) over full slots.
REQ-020 SHALL grant at most one slot per cycle; at the edge (rdy=1, flush=0), load winner's tag/value/index into cdb_tag/cdb_value/cdb_src, set cdb_valid=1, clear the winner's full bit, set ptr=(winner+1) mod 3.
REQ-021 SHALL, with no full slot at an enabled edge, set cdb_valid=0, leave ptr, cdb_tag, cdb_value, cdb_src unchanged.
REQ-022 SHALL give uncontested latency of 2 cycles: valid presented in cycle t -> slot full in t+1 -> cdb_valid=1 in t+2; each grant is a 1-cycle cdb_valid pulse.
REQ-023 SHALL never accept into and grant from the same slot at one edge (acceptance requires empty slot); another slot may accept while one is granted.
REQ-024 SHALL bound wait: a full slot is granted within 3 enabled cycles of becoming full.
REQ-025 SHALL, on flush=1 at an edge (rdy=1), clear all full bits, set cdb_valid=0, ptr=0, accept nothing; flush overrides accept and grant.
REQ-026 SHALL, when rdy=0, hold all registers including cdb_valid/tag/value/src and ptr; flush and valid inputs are ignored.
REQ-027 SHALL never encode ptr or cdb_src as 3.

Reset
REQ-028 SHALL, while rst=0 (asynchronously), clear full bits, ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0; ready outputs read 1.
REQ-029 SHALL resume normal operation at the first rising edge with rst=1; reset mid-operation discards all held results.

Verification
REQ-030 SHALL cover: alu1_valid=1, tag=5, value=0x1234 in cycle t alone -> cdb_valid=1, tag=5, value=0x1234, src=0 in cycle t+2 only.
REQ-031 SHALL cover: all three valid same cycle (tags 1,2,3), ptr=0 -> grants src 0,1,2 on three consecutive cycles, ptr ends 0.
REQ-032 SHALL cover: ld slot full and alu1 re-requesting every cycle with ptr=0 -> grants alternate alu1, ld; ld waits ≤2 grants.
REQ-033 SHALL cover: alu2 slot full, rdy=0 for 4 cycles -> cdb outputs and alu2_ready=0 frozen; grant on first rdy=1 edge.
REQ-034 SHALL cover: two slots full, flush=1 for one cycle with alu1_valid=1 -> all ready=1, cdb_valid=0, nothing captured, ptr=0.
REQ-035 SHALL cover: rst driven low mid-cycle with cdb_valid=1 -> cdb_valid=0 immediately, before next clock edge.
